// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer slice.
// Holds the default widths, the tap-count width and the sequencer state encoding.
package mac_pkg;

    localparam int unsigned IN_WIDTH  = 8;
    localparam int unsigned OUT_WIDTH = 22;
    localparam int unsigned MAX_TAPS  = 64;
    // One extra bit so the count can hold MAX_TAPS itself.
    localparam int unsigned CNT_WIDTH = $clog2(MAX_TAPS) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StCapture,
        StDone
    } state_e;

endpackage

// File: rtl/tap_counter.sv
// Tap counter for the MAC sequencer.
// Counts operand handshakes within a job and flags the handshake that reaches the target.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (start of job)
//   inc        : handshake this cycle
//   target     : latched product count for the job
//   last       : inc is the handshake that reaches target
module tap_counter #(
    parameter int unsigned CNT_WIDTH = mac_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 inc,
    input  logic [CNT_WIDTH-1:0] target,
    output logic                 last
);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] count_inc;

    assign count_inc = count_q + CNT_WIDTH'(1);
    assign last      = inc && (count_inc == target);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mac_seq.sv
// MAC job sequencer.
// Runs one dot-product job on an external MAC peer: clears it, streams operand pairs through
// it with a valid/ready handshake, waits for the last accumulate and captures the result.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, num_taps      : job request and product count (sampled in IDLE)
//   abort                : cancel the running job
//   busy, done, result   : status, one-cycle completion pulse, captured dot product
//   in_valid, in_ready   : operand pair handshake; img_in, weight_in operands
//   rst_mem, mul_mem_en, ac_mem_en, mac_img, mac_weight : MAC control and operands
//   mac_out              : MAC accumulator value
module mac_seq #(
    parameter int unsigned IN_WIDTH  = mac_pkg::IN_WIDTH,
    parameter int unsigned OUT_WIDTH = mac_pkg::OUT_WIDTH,
    parameter int unsigned MAX_TAPS  = mac_pkg::MAX_TAPS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [$clog2(MAX_TAPS):0]   num_taps,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic [OUT_WIDTH-1:0]        result,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_WIDTH-1:0]         img_in,
    input  logic [IN_WIDTH-1:0]         weight_in,
    output logic                        rst_mem,
    output logic                        mul_mem_en,
    output logic                        ac_mem_en,
    output logic [IN_WIDTH-1:0]         mac_img,
    output logic [IN_WIDTH-1:0]         mac_weight,
    input  logic [OUT_WIDTH-1:0]        mac_out
);

    import mac_pkg::*;

    localparam int unsigned         CntWidth   = $clog2(MAX_TAPS) + 1;
    localparam logic [CntWidth-1:0] MaxTapsCnt = CntWidth'(MAX_TAPS);

    // Worst-case sum must fit the accumulator.
    localparam longint unsigned MaxOperand = (64'd1 << IN_WIDTH) - 64'd1;
    localparam longint unsigned MaxSum     = 64'(MAX_TAPS) * MaxOperand * MaxOperand;
    localparam longint unsigned AccLimit   = 64'd1 << OUT_WIDTH;

    if (MaxSum >= AccLimit) begin : g_overflow_check
        $error("mac_seq: OUT_WIDTH too small for MAX_TAPS products of IN_WIDTH operands");
    end

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   taps_q, taps_d;
    logic [OUT_WIDTH-1:0]  result_q, result_d;
    logic                  ac_q;
    logic                  tap_last;
    logic                  kill;

    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign rst_mem    = (state_q == StClear);
    assign in_ready   = (state_q == StStream);
    assign mul_mem_en = in_valid && in_ready;
    assign ac_mem_en  = ac_q;
    assign mac_img    = img_in;
    assign mac_weight = weight_in;
    assign result     = result_q;
    assign kill       = abort && busy;

    tap_counter #(
        .CNT_WIDTH (CntWidth)
    ) u_tap_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (rst_mem),
        .inc    (mul_mem_en),
        .target (taps_q),
        .last   (tap_last)
    );

    always_comb begin
        state_d  = state_q;
        taps_d   = taps_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    taps_d  = (num_taps > MaxTapsCnt) ? MaxTapsCnt : num_taps;
                    state_d = StClear;
                end
            end
            StClear:   state_d = (taps_q == '0) ? StCapture : StStream;
            StStream:  if (tap_last) state_d = StDrain;
            StDrain:   state_d = StCapture;
            StCapture: begin
                result_d = mac_out;
                state_d  = StDone;
            end
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        // Abort overrides every other transition, including the capture.
        if (kill) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            taps_q   <= '0;
            result_q <= '0;
            ac_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            taps_q   <= taps_d;
            result_q <= result_d;
            // Accumulate one cycle after the product register loads.
            ac_q     <= kill ? 1'b0 : mul_mem_en;
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Directed testbench for mac_seq with a behavioural MAC peer.
module tb_mac_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  num_taps;
    logic        abort;
    logic        busy;
    logic        done;
    logic [21:0] result;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  img_in;
    logic [7:0]  weight_in;
    logic        rst_mem;
    logic        mul_mem_en;
    logic        ac_mem_en;
    logic [7:0]  mac_img;
    logic [7:0]  mac_weight;
    logic [21:0] mac_out;

    int checks = 0;
    int errors = 0;

    mac_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_taps   (num_taps),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .img_in     (img_in),
        .weight_in  (weight_in),
        .rst_mem    (rst_mem),
        .mul_mem_en (mul_mem_en),
        .ac_mem_en  (ac_mem_en),
        .mac_img    (mac_img),
        .mac_weight (mac_weight),
        .mac_out    (mac_out)
    );

    // Behavioural MAC peer: product register then accumulator.
    logic [15:0] mul_q;
    logic [21:0] acc_q;
    assign mac_out = acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_q <= '0;
            acc_q <= '0;
        end else if (rst_mem) begin
            mul_q <= '0;
            acc_q <= '0;
        end else begin
            if (mul_mem_en) mul_q <= mac_img * mac_weight;
            if (ac_mem_en)  acc_q <= acc_q + 22'(mul_q);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one job starting in the current cycle (cycle 0). mode selects operands:
    // 0 -> (2k+1, 2k+2), 1 -> (255, 255), 2 -> (1, 1).
    task automatic run_job(input int n, input int mode, input bit bubble, input int abort_after,
                           input int restart_cyc, output int done_cyc, output int n_done,
                           output int n_mul, output int pipe_err);
        int  k;
        int  abort_c;
        bit  prev_mul;
        bit  aborted;
        k        = 0;
        abort_c  = 0;
        prev_mul = 1'b0;
        aborted  = 1'b0;
        done_cyc = -1;
        n_done   = 0;
        n_mul    = 0;
        pipe_err = 0;
        for (int c = 0; c < 200; c++) begin
            start    = (c == 0) || (c == restart_cyc);
            num_taps = (c == restart_cyc) ? 7'd10 : 7'(n);
            abort    = 1'b0;
            in_valid = bubble ? (c % 2 == 0) : 1'b1;
            if (abort_after > 0 && k == abort_after && !aborted) begin
                abort    = 1'b1;
                in_valid = 1'b0;
                aborted  = 1'b1;
                abort_c  = c;
            end
            case (mode)
                0:       begin img_in = 8'(2 * k + 1); weight_in = 8'(2 * k + 2); end
                1:       begin img_in = 8'd255;        weight_in = 8'd255;        end
                default: begin img_in = 8'd1;          weight_in = 8'd1;          end
            endcase
            #1;
            if (ac_mem_en !== prev_mul) pipe_err++;
            prev_mul = mul_mem_en;
            if (mul_mem_en) n_mul++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(posedge clk);
            #1;
            if (prev_mul) k++;
            if (abort) begin
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_ac", 32'(ac_mem_en), 32'd0);
                abort = 1'b0;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
            if (aborted && c >= abort_c + 4) break;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    int dc, nd, nm, pe;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        num_taps  = '0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        img_in    = '0;
        weight_in = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_rst_mem", 32'(rst_mem), 32'd0);
        check("rst_ac", 32'(ac_mem_en), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Basic job: 1*2 + 3*4 + 5*6 = 44
        run_job(3, 0, 1'b0, 0, -1, dc, nd, nm, pe);
        check("basic_result", 32'(result), 32'd44);
        check("basic_done_cyc", 32'(dc), 32'd7);
        check("basic_done_cnt", 32'(nd), 32'd1);
        check("basic_mul_cnt", 32'(nm), 32'd3);
        check("basic_pipe", 32'(pe), 32'd0);

        // Abort while idle does nothing.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);
        check("idle_abort_result", 32'(result), 32'd44);

        // Zero taps
        run_job(0, 1, 1'b0, 0, -1, dc, nd, nm, pe);
        check("zero_result", 32'(result), 32'd0);
        check("zero_done_cyc", 32'(dc), 32'd3);
        check("zero_mul_cnt", 32'(nm), 32'd0);

        // Bubbles: 4 * 65025 = 260100, handshakes in cycles 2,4,6,8
        run_job(4, 1, 1'b1, 0, -1, dc, nd, nm, pe);
        check("bubble_result", 32'(result), 32'd260100);
        check("bubble_done_cyc", 32'(dc), 32'd11);
        check("bubble_mul_cnt", 32'(nm), 32'd4);
        check("bubble_pipe", 32'(pe), 32'd0);

        // Full length: 64 * 65025 = 4161600
        run_job(64, 1, 1'b0, 0, -1, dc, nd, nm, pe);
        check("full_result", 32'(result), 32'd4161600);
        check("full_done_cyc", 32'(dc), 32'd68);
        check("full_mul_cnt", 32'(nm), 32'd64);

        // Saturation: 100 clipped to 64
        run_job(100, 1, 1'b0, 0, -1, dc, nd, nm, pe);
        check("sat_result", 32'(result), 32'd4161600);
        check("sat_done_cyc", 32'(dc), 32'd68);
        check("sat_mul_cnt", 32'(nm), 32'd64);

        // Abort after the 2nd handshake
        run_job(3, 0, 1'b0, 2, -1, dc, nd, nm, pe);
        check("abort_done_cnt", 32'(nd), 32'd0);
        check("abort_result", 32'(result), 32'd4161600);
        check("abort_mul_cnt", 32'(nm), 32'd2);

        // Follow-up job after abort: three (1,1) -> 3
        run_job(3, 2, 1'b0, 0, -1, dc, nd, nm, pe);
        check("post_abort_result", 32'(result), 32'd3);
        check("post_abort_done_cyc", 32'(dc), 32'd7);

        // Reset asserted mid-stream
        start     = 1'b1;
        num_taps  = 7'd5;
        in_valid  = 1'b1;
        img_in    = 8'd255;
        weight_in = 8'd255;
        step();
        start = 1'b0;
        step();
        step();
        check("pre_rst_in_ready", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_mul", 32'(mul_mem_en), 32'd0);
        check("midrst_ac", 32'(ac_mem_en), 32'd0);
        check("midrst_rst_mem", 32'(rst_mem), 32'd0);
        step();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) nd++;
        end
        in_valid = 1'b0;
        check("midrst_no_done", 32'(nd), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);

        // Start pulsed while busy is ignored
        run_job(3, 0, 1'b0, 0, 3, dc, nd, nm, pe);
        check("restart_result", 32'(result), 32'd44);
        check("restart_done_cyc", 32'(dc), 32'd7);
        check("restart_done_cnt", 32'(nd), 32'd1);
        check("restart_mul_cnt", 32'(nm), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
